// File: rtl/conv_pkg.sv
// Shared widths, types and saturation helper for the 3x3 streaming convolution engine.
package conv_pkg;
   localparam int DATA_W    = 8;
   localparam int KSIZE     = 3;
   localparam int NTAPS     = KSIZE * KSIZE;
   localparam int FRAC_BITS = 7;
   localparam int PROD_W    = 2 * DATA_W;
   localparam int ACC_W     = 20;

   typedef logic signed [DATA_W-1:0] pixel_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   localparam acc_t SAT_MAX = acc_t'((2 ** (DATA_W - 1)) - 1);
   localparam acc_t SAT_MIN = acc_t'(-(2 ** (DATA_W - 1)));

   function automatic pixel_t sat_pixel(input acc_t v);
      if (v > SAT_MAX) begin
         return pixel_t'(SAT_MAX);
      end else if (v < SAT_MIN) begin
         return pixel_t'(SAT_MIN);
      end else begin
         return pixel_t'(v);
      end
   endfunction
endpackage

// File: rtl/conv_2d_mac.sv
// Combinational 9-tap signed dot product with arithmetic shift and 8-bit saturation.
module conv_2d_mac
   import conv_pkg::*;
(
   input  pixel_t win [NTAPS],
   input  pixel_t knl [NTAPS],
   output pixel_t pixel
);

   acc_t acc;
   acc_t shifted;

   // win is row-major oldest-first and knl is K1..K9, so reversing knl gives true convolution.
   always_comb begin
      // NOTE: acc gets a value before the loop reads it, so every path assigns it and no latch forms.
      acc = '0;
      for (int i = 0; i < NTAPS; i++) begin
         acc = acc + acc_t'(prod_t'(win[i]) * prod_t'(knl[NTAPS-1-i]));
      end
      shifted = acc >>> FRAC_BITS;
      pixel   = sat_pixel(shifted);
   end

endmodule

// File: rtl/conv_2d_3x3.sv
// Streaming 3x3 convolution: kernel shift-load, two stored pixel rows and a registered output.
module conv_2d_3x3
   import conv_pkg::*;
(
   input  logic                     clk,
   input  logic                     i_nrst,
   input  logic                     i_en_conv,
   input  logic                     i_load_knl,
   input  logic                     i_data_valid,
   input  logic signed [DATA_W-1:0] i_data1,
   input  logic signed [DATA_W-1:0] i_data2,
   input  logic signed [DATA_W-1:0] i_data3,
   output logic signed [DATA_W-1:0] o_pixel
);

   pixel_t knl  [NTAPS];
   pixel_t row0 [KSIZE];
   pixel_t row1 [KSIZE];
   pixel_t win  [NTAPS];
   pixel_t mac_pixel;

   // Both strobes belong to the host protocol and never touch the datapath.
   logic unused_ok;
   assign unused_ok = &{1'b0, i_en_conv, i_data_valid};

   always_comb begin
      for (int c = 0; c < KSIZE; c++) begin
         win[c]         = row0[c];
         win[KSIZE + c] = row1[c];
      end
      win[2*KSIZE]     = i_data1;
      win[2*KSIZE + 1] = i_data2;
      win[2*KSIZE + 2] = i_data3;
   end

   conv_2d_mac u_mac (
      .win   (win),
      .knl   (knl),
      .pixel (mac_pixel)
   );

   // NOTE: state updates use <= so every register samples pre-edge values and the shifts stay ordered.
   always_ff @(posedge clk) begin
      if (!i_nrst) begin
         // NOTE: the kernel and row storage are cleared on reset because a reset must leave a zero kernel.
         knl     <= '{default: '0};
         row0    <= '{default: '0};
         row1    <= '{default: '0};
         o_pixel <= '0;
      end else if (i_load_knl) begin
         for (int i = 0; i < KSIZE; i++) begin
            knl[2*KSIZE + i] <= knl[KSIZE + i];
            knl[KSIZE + i]   <= knl[i];
         end
         knl[0] <= i_data3;
         knl[1] <= i_data2;
         knl[2] <= i_data1;
      end else begin
         row0    <= row1;
         row1    <= '{i_data1, i_data2, i_data3};
         o_pixel <= mac_pixel;
      end
   end

endmodule

// File: tb/tb_conv_2d_3x3.sv
// Self-checking bench: directed steps plus random stimulus against a queue-based convolution model.
module tb_conv_2d_3x3;
   typedef int trip_t [3];

   logic              clk;
   logic              i_nrst;
   logic              i_en_conv;
   logic              i_load_knl;
   logic              i_data_valid;
   logic signed [7:0] i_data1;
   logic signed [7:0] i_data2;
   logic signed [7:0] i_data3;
   logic signed [7:0] o_pixel;

   int n_tests = 0;
   int n_fail  = 0;

   trip_t             ld_q[$];
   trip_t             row_q[$];
   logic signed [7:0] exp_pix;

   conv_2d_3x3 dut (
      .clk          (clk),
      .i_nrst       (i_nrst),
      .i_en_conv    (i_en_conv),
      .i_load_knl   (i_load_knl),
      .i_data_valid (i_data_valid),
      .i_data1      (i_data1),
      .i_data2      (i_data2),
      .i_data3      (i_data3),
      .o_pixel      (o_pixel)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic signed [7:0] obs, input logic signed [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ld_q.delete();
      row_q.delete();
      for (int i = 0; i < 3; i++) begin
         ld_q.push_back('{0, 0, 0});
         row_q.push_back('{0, 0, 0});
      end
      exp_pix = 0;
   endtask

   // Load j (oldest of the last three) carries K(9-3j), K(8-3j), K(7-3j) on data1..3.
   function automatic int conv_ref(input trip_t r0, input trip_t r1, input trip_t r2);
      int k [10];
      trip_t w [3];
      int acc;
      int q;
      for (int j = 0; j < 3; j++)
         for (int c = 0; c < 3; c++)
            k[9 - 3*j - c] = ld_q[j][c];
      w[0] = r0; w[1] = r1; w[2] = r2;
      acc = 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            acc += w[r][c] * k[9 - 3*r - c];
      q = acc >>> 7;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return q;
   endfunction

   task automatic cycle(input string tag, input bit rst, input bit ld, input int d1, input int d2, input int d3);
      trip_t t;
      t = '{d1, d2, d3};
      i_nrst       = !rst;
      i_load_knl   = ld;
      i_data1      = 8'(d1);
      i_data2      = 8'(d2);
      i_data3      = 8'(d3);
      i_data_valid = 1'($urandom);
      i_en_conv    = 1'($urandom);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (ld) begin
         ld_q.push_back(t);
         void'(ld_q.pop_front());
      end else begin
         exp_pix = 8'(conv_ref(row_q[1], row_q[2], t));
         row_q.push_back(t);
         void'(row_q.pop_front());
      end
      @(negedge clk);
      check(tag, o_pixel, exp_pix);
   endtask

   function automatic int rpix();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   initial begin
      int vals [4];
      int outs [4];
      vals = '{10, 100, -128, 127};
      outs = '{9, 99, -127, 126};
      i_nrst = 1'b0; i_load_knl = 1'b0; i_data_valid = 1'b0; i_en_conv = 1'b0;
      i_data1 = '0; i_data2 = '0; i_data3 = '0;
      model_reset();
      @(negedge clk);

      // Reset, idle, then zero-kernel streaming.
      cycle("reset", 1, 0, 0, 0, 0);
      cycle("reset_hold", 1, 0, 55, -3, 9);
      check("reset_zero", o_pixel, 8'sd0);
      for (int i = 0; i < 4; i++) cycle("idle", 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle("zero_knl", 0, 0, rpix(), rpix(), rpix());
      check("zero_knl_out", o_pixel, 8'sd0);

      // Identity kernel: centre tap only.
      cycle("ld_id0", 0, 1, 0, 0, 0);
      cycle("ld_id1", 0, 1, 0, 127, 0);
      cycle("ld_id2", 0, 1, 0, 0, 0);
      for (int v = 0; v < 4; v++) begin
         for (int r = 0; r < 3; r++) cycle("ident", 0, 0, rpix(), vals[v], rpix());
         check("ident_val", o_pixel, 8'(outs[v]));
      end

      // K1 only: output is the previous data3 scaled by 127/128.
      cycle("ld_k1_0", 0, 1, 0, 0, 0);
      cycle("ld_k1_1", 0, 1, 0, 0, 0);
      cycle("ld_k1_2", 0, 1, 0, 0, 127);
      for (int i = 0; i < 10; i++) begin
         int d3;
         d3 = rpix();
         cycle("k1_flip", 0, 0, rpix(), rpix(), d3);
         check("k1_direct", o_pixel, 8'((d3 * 127) >>> 7));
      end

      // All-ones kernel: saturation in both directions.
      for (int i = 0; i < 3; i++) cycle("ld_all", 0, 1, 127, 127, 127);
      for (int i = 0; i < 3; i++) cycle("sat_pos", 0, 0, 127, 127, 127);
      check("sat_max", o_pixel, 8'sd127);
      for (int i = 0; i < 3; i++) cycle("sat_neg", 0, 0, -128, -128, -128);
      check("sat_min", o_pixel, -8'sd128);

      // Four load cycles: o_pixel holds, only the last three loads remain.
      for (int i = 0; i < 4; i++) begin
         cycle("ld4_hold", 0, 1, rpix(), rpix(), rpix());
         check("ld4_hold_min", o_pixel, -8'sd128);
      end
      for (int i = 0; i < 12; i++) cycle("ld4_stream", 0, 0, rpix(), rpix(), rpix());

      // Random kernels, random pixels, occasional reloads.
      for (int i = 0; i < 300; i++) begin
         bit ld;
         ld = ($urandom_range(0, 9) == 0);
         cycle("rand", 0, ld, rpix(), rpix(), rpix());
      end

      // Mid-strip reset clears rows and kernel; outputs stay zero until reload.
      for (int i = 0; i < 3; i++) cycle("ld_pre_rst", 0, 1, rpix(), rpix(), rpix());
      for (int i = 0; i < 5; i++) cycle("pre_rst", 0, 0, rpix(), rpix(), rpix());
      cycle("mid_rst", 1, 0, rpix(), rpix(), rpix());
      check("mid_rst_zero", o_pixel, 8'sd0);
      for (int i = 0; i < 8; i++) cycle("post_rst", 0, 0, rpix(), rpix(), rpix());
      check("post_rst_zero", o_pixel, 8'sd0);
      cycle("reld0", 0, 1, 0, 0, 0);
      cycle("reld1", 0, 1, 0, 127, 0);
      cycle("reld2", 0, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle("reld_stream", 0, 0, rpix(), rpix(), rpix());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
